// File: rtl/alu_source_a_mux.sv
// ALU source-A operand selector.
// Picks one of four equal-width candidate operands by the 2-bit ALUSrcA code
// and presents it to the ALU A input, registered by default so the ALU sees a
// clean flop output. The register can be dropped by parameter for a purely
// combinational path.
module alu_source_a_mux #(
   parameter int WIDTH      = 16,
   parameter bit REGISTERED = 1'b1
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic [1:0]       ALUSrcA,
   input  logic [WIDTH-1:0] Zero,
   input  logic [WIDTH-1:0] One,
   input  logic [WIDTH-1:0] Two,
   input  logic [WIDTH-1:0] Three,
   output logic [WIDTH-1:0] Output
);

   // Selected operand before the optional output register.
   logic [WIDTH-1:0] mux_d;

   // Full four-way decode; an unknown select falls back to the Zero source so
   // the ALU never sees a floating operand.
   always_comb begin
      mux_d = Zero;
      case (ALUSrcA)
         2'd0:    mux_d = Zero;
         2'd1:    mux_d = One;
         2'd2:    mux_d = Two;
         2'd3:    mux_d = Three;
         default: mux_d = Zero;
      endcase
   end

   if (REGISTERED) begin : g_reg
      logic [WIDTH-1:0] out_q;

      // Reload every cycle; synchronous reset wins over select and data.
      always_ff @(posedge CLK) begin
         if (Reset) begin
            out_q <= '0;
         end else begin
            out_q <= mux_d;
         end
      end

      assign Output = out_q;
   end else begin : g_comb
      // Clock and reset have no role in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ Reset;

      assign Output = mux_d;
   end

endmodule

// File: tb/tb_alu_source_a_mux.sv
// Bench for alu_source_a_mux: directed vector table, a hand-written glitch
// sequence, randomized traffic against a reference model, and a check of the
// combinational build.
module tb_alu_source_a_mux;

   localparam int W = 16;

   logic          clk;
   logic          rst;
   logic [1:0]    sel;
   logic [W-1:0]  src_zero, src_one, src_two, src_three;
   logic [W-1:0]  out_reg, out_comb;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];

   alu_source_a_mux #(.WIDTH(W), .REGISTERED(1'b1)) dut_reg (
      .CLK(clk), .Reset(rst), .ALUSrcA(sel),
      .Zero(src_zero), .One(src_one), .Two(src_two), .Three(src_three),
      .Output(out_reg)
   );

   alu_source_a_mux #(.WIDTH(W), .REGISTERED(1'b0)) dut_comb (
      .CLK(clk), .Reset(rst), .ALUSrcA(sel),
      .Zero(src_zero), .One(src_one), .Two(src_two), .Three(src_three),
      .Output(out_comb)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   // Next registered output: zero under reset, otherwise the source chosen
   // by the select code, looked up as an array element.
   function automatic logic [W-1:0] model(input logic r, input logic [1:0] s,
                                          input logic [W-1:0] z, input logic [W-1:0] o,
                                          input logic [W-1:0] t, input logic [W-1:0] th);
      logic [W-1:0] srcs[4];
      srcs[0] = z; srcs[1] = o; srcs[2] = t; srcs[3] = th;
      if (r) return '0;
      return srcs[s];
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic [1:0] s, input logic [W-1:0] z,
                        input logic [W-1:0] o, input logic [W-1:0] t, input logic [W-1:0] th);
      @(negedge clk);
      rst = r; sel = s;
      src_zero = z; src_one = o; src_two = t; src_three = th;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int           tid;
      logic         r;
      logic [1:0]   s;
      logic [W-1:0] z, o, t, th;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int tid, input logic r, input logic [1:0] s,
                               input logic [W-1:0] z, input logic [W-1:0] o,
                               input logic [W-1:0] t, input logic [W-1:0] th,
                               input logic [W-1:0] exp);
      vec_t v;
      v.tid = tid; v.r = r; v.s = s; v.z = z; v.o = o; v.t = t; v.th = th; v.exp = exp;
      return v;
   endfunction

   initial begin
      logic [W-1:0] e;
      logic [1:0]   rs;
      logic         rr;
      logic [W-1:0] rz, ro, rt, rth;
      logic [W-1:0] srcs[4];

      rst = 1'b1; sel = 2'd0;
      src_zero = '0; src_one = '0; src_two = '0; src_three = '0;

      // reset held two cycles, select pointing at a nonzero source
      vecs.push_back(mk(1, 1'b1, 2'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'h0000));
      vecs.push_back(mk(1, 1'b1, 2'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'h0000));
      // select sweep, first non-reset edge loads immediately
      vecs.push_back(mk(2, 1'b0, 2'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0));
      vecs.push_back(mk(2, 1'b0, 2'd1, 16'd0, 16'd1, 16'd2, 16'd3, 16'd1));
      vecs.push_back(mk(2, 1'b0, 2'd2, 16'd0, 16'd1, 16'd2, 16'd3, 16'd2));
      vecs.push_back(mk(2, 1'b0, 2'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3));
      // data tracking on select 2, unrelated sources churning
      vecs.push_back(mk(3, 1'b0, 2'd2, 16'h5555, 16'hAAAA, 16'h1234, 16'h0F0F, 16'h1234));
      vecs.push_back(mk(3, 1'b0, 2'd2, 16'h5555, 16'hAAAA, 16'hFFFF, 16'h0F0F, 16'hFFFF));
      vecs.push_back(mk(3, 1'b0, 2'd2, 16'h0001, 16'h8000, 16'hFFFF, 16'hF0F0, 16'hFFFF));
      // width edges: all bits toggling
      vecs.push_back(mk(4, 1'b0, 2'd3, 16'h0000, 16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF));
      vecs.push_back(mk(4, 1'b0, 2'd0, 16'h0000, 16'h1111, 16'h2222, 16'hFFFF, 16'h0000));
      vecs.push_back(mk(4, 1'b0, 2'd3, 16'h0000, 16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF));
      vecs.push_back(mk(4, 1'b0, 2'd0, 16'h0000, 16'h1111, 16'h2222, 16'hFFFF, 16'h0000));
      // reset pulse mid-stream
      vecs.push_back(mk(5, 1'b0, 2'd1, 16'h0000, 16'hABCD, 16'h2222, 16'h3333, 16'hABCD));
      vecs.push_back(mk(5, 1'b1, 2'd1, 16'h0000, 16'hABCD, 16'h2222, 16'h3333, 16'h0000));
      vecs.push_back(mk(5, 1'b0, 2'd1, 16'h0000, 16'hABCD, 16'h2222, 16'h3333, 16'hABCD));

      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].s, vecs[i].z, vecs[i].o, vecs[i].t, vecs[i].th);
         exp_q.push_back(vecs[i].exp);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         check($sformatf("vec%0d_test%0d", i, vecs[i].tid), out_reg, e);
      end

      // glitch between edges: register holds, only the edge value is captured
      drive(1'b0, 2'd1, 16'h0A0A, 16'h1B1B, 16'h2C2C, 16'h3D3D);
      @(posedge clk); #1;
      check("glitch_load", out_reg, 16'h1B1B);
      sel = 2'd3; src_one = 16'h7777;
      #1;
      check("glitch_hold", out_reg, 16'h1B1B);
      sel = 2'd2;
      @(posedge clk); #1;
      check("glitch_edge", out_reg, 16'h2C2C);

      // randomized traffic against the model
      for (int n = 0; n < 300; n++) begin
         rr  = ($urandom_range(0, 15) == 0);
         rs  = 2'($urandom_range(0, 3));
         rz  = W'($urandom); ro = W'($urandom); rt = W'($urandom); rth = W'($urandom);
         drive(rr, rs, rz, ro, rt, rth);
         exp_q.push_back(model(rr, rs, rz, ro, rt, rth));
         @(posedge clk); #1;
         e = exp_q.pop_front();
         check($sformatf("rand%0d", n), out_reg, e);
      end

      // combinational build: output follows inputs after a short delay,
      // reset asserted to show it is ignored
      rst = 1'b1;
      for (int n = 0; n < 40; n++) begin
         sel = 2'(n % 4);
         src_zero = W'($urandom); src_one = W'($urandom);
         src_two = W'($urandom); src_three = W'($urandom);
         srcs[0] = src_zero; srcs[1] = src_one; srcs[2] = src_two; srcs[3] = src_three;
         #1;
         check($sformatf("comb%0d", n), out_comb, srcs[n % 4]);
         #2;
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
